// File: rtl/seven_seg_scan_pkg.sv
// Shared definitions for the seven-segment scanner: segment patterns, blank levels, buffer layout.
// All patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
    } frame_t;

    // A digit is a leading zero when it and every digit to its left are zero; digit 0 always shows.
    function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] i, input logic en);
        logic b;
        b = 1'b0;
        case (i)
            2'd3:    b = (v[15:12] == 4'd0);
            2'd2:    b = (v[15:8] == 8'd0);
            2'd1:    b = (v[15:4] == 12'd0);
            default: b = 1'b0;
        endcase
        return en & b;
    endfunction

endpackage

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Purpose: nibble to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module hex_to_seg
    import seven_seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Purpose: multiplex a 4-digit common-anode display, one digit per rising edge of scan_clk.
// Latency: outputs move on the 3rd clk edge after scan_clk rises; new values commit at frame wrap.
// Backpressure: none; value_wr always accepted, last write before a wrap wins.
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan_clk,
    input  logic [15:0]           value,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  blank_lz,
    input  logic                  value_wr,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic                   scan_en_q, scan_en_d;
    logic [1:0]             idx_q, idx_d;
    frame_t                 display_q, display_d;
    frame_t                 pending_q, pending_d;
    logic                   pending_vld_q, pending_vld_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic                   frame_done_q, frame_done_d;

    logic                   tick;
    logic                   wrap;
    logic [3:0]             nibble;
    logic [6:0]             nibble_seg;

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (nibble_seg)
    );

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], scan_clk};
        edge_d = sync_q[SYNC_STAGES-1];
        tick   = sync_q[SYNC_STAGES-1] & ~edge_q;
        wrap   = tick & scan_en_q & (idx_q == 2'd3);

        scan_en_d     = scan_en_q;
        idx_d         = idx_q;
        display_d     = display_q;
        pending_d     = pending_q;
        pending_vld_d = pending_vld_q;
        frame_done_d  = 1'b0;

        // First tick only enables the scan so digit 0 gets a full slot.
        if (tick) begin
            if (!scan_en_q) begin
                scan_en_d = 1'b1;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end

        if (wrap) begin
            frame_done_d = 1'b1;
            if (pending_vld_q) begin
                display_d     = pending_q;
                pending_vld_d = 1'b0;
            end
        end

        // A write on the wrap cycle lands in pending after the old pending has been committed.
        if (value_wr) begin
            pending_d     = '{value: value, dp: dp_in};
            pending_vld_d = 1'b1;
        end

        nibble = display_d.value[{idx_d, 2'b00} +: 4];

        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (scan_en_d && !lz_blank(display_d.value, idx_d, blank_lz)) begin
            an_d  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d);
            seg_d = nibble_seg;
            dp_d  = ~display_d.dp[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q        <= '0;
            edge_q        <= 1'b0;
            scan_en_q     <= 1'b0;
            idx_q         <= 2'd0;
            display_q     <= '0;
            pending_q     <= '0;
            pending_vld_q <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            edge_q        <= edge_d;
            scan_en_q     <= scan_en_d;
            idx_q         <= idx_d;
            display_q     <= display_d;
            pending_q     <= pending_d;
            pending_vld_q <= pending_vld_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
